// File: rtl/jtframe_frac_cen_ctrl.sv
// jtframe_frac_cen_ctrl: glitch-free n/m updates on cen boundaries, pause gating, optional JTFRAME_CEN_WDOG_EN watchdog
module jtframe_frac_cen_ctrl #(
   parameter int DEF_N  = 1,
   parameter int DEF_M  = 2,
   parameter int SETTLE = 2,
   parameter int TOW    = 12
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] cfg_n,
   input  logic [9:0] cfg_m,
   input  logic       cfg_req,
   output logic       cfg_ack,
   output logic       cfg_bad,
   input  logic       pause,
   output logic       paused,
   input  logic       cen_in,
   output logic [9:0] n,
   output logic [9:0] m,
   output logic       cen,
   output logic       busy,
   output logic       wdog_err
);
   typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_SETL, ST_PAUSED} state_t;
   state_t st;
   logic [9:0] sh_n, sh_m;
   logic [3:0] scnt;
   logic [TOW-1:0] wcnt;
   logic gate, armed, ok, take, wd_hit;
   assign ok     = cfg_m != '0 && cfg_n != '0 && cfg_n <= cfg_m;
   assign take   = cfg_req & armed;
   assign cen    = cen_in & ~gate;
   assign busy   = st == ST_ARM || st == ST_SETL;
   assign paused = st == ST_PAUSED;
   assign wd_hit = &wcnt;
`ifdef JTFRAME_CEN_WDOG_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) wcnt <= '0;
      else wcnt <= (cen_in || st == ST_PAUSED || st == ST_SETL || wd_hit) ? '0 : wcnt + TOW'(1);
`else
   assign wcnt = '0;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st       <= ST_IDLE;
         n        <= 10'(DEF_N);
         m        <= 10'(DEF_M);
         sh_n     <= '0;
         sh_m     <= '0;
         scnt     <= '0;
         gate     <= 1'b0;
         armed    <= 1'b1;
         cfg_ack  <= 1'b0;
         cfg_bad  <= 1'b0;
         wdog_err <= 1'b0;
      end else begin
         cfg_ack <= 1'b0;
         cfg_bad <= 1'b0;
         if (!cfg_req) armed <= 1'b1;
         if (wd_hit) begin
            // enables stopped: fall back to the default ratio, aborting any pending update
            wdog_err <= 1'b1;
            n        <= 10'(DEF_N);
            m        <= 10'(DEF_M);
            gate     <= 1'b0;
            st       <= ST_IDLE;
            if (st == ST_ARM) begin
               cfg_ack <= 1'b1;
               cfg_bad <= 1'b1;
            end
         end else case (st)
            ST_IDLE:
               if (take) begin
                  armed <= 1'b0;
                  if (ok) begin
                     sh_n <= cfg_n;
                     sh_m <= cfg_m;
                     st   <= ST_ARM;
                  end else begin
                     cfg_ack <= 1'b1;
                     cfg_bad <= 1'b1;
                  end
               end else if (pause) begin
                  gate <= 1'b1;
                  st   <= ST_PAUSED;
               end
            ST_ARM:
               if (cen_in) begin
                  n    <= sh_n;
                  m    <= sh_m;
                  gate <= 1'b1;
                  scnt <= 4'(SETTLE - 1);
                  st   <= ST_SETL;
               end
            ST_SETL:
               if (scnt == '0) begin
                  cfg_ack  <= 1'b1;
                  wdog_err <= 1'b0;
                  gate     <= 1'b0;
                  st       <= ST_IDLE;
               end else scnt <= scnt - 4'd1;
            ST_PAUSED: begin
               // output is already gated, so the ratio can change without waiting for an edge
               if (take) begin
                  armed   <= 1'b0;
                  cfg_ack <= 1'b1;
                  cfg_bad <= ~ok;
                  if (ok) begin
                     n        <= cfg_n;
                     m        <= cfg_m;
                     wdog_err <= 1'b0;
                  end
               end
               if (!pause) begin
                  gate <= 1'b0;
                  st   <= ST_IDLE;
               end
            end
         endcase
      end
endmodule
